pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 16-bit in-order pipeline (IF, ID, EX1, EX2, WB).
- Drives the hold/bubble controls of the IF/ID, ID/EX1 and EX1/EX2 pipeline registers.
- Detects load-use hazards, freezes EX1 for multi-cycle ops, and sequences redirect flushes.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
- REG_W, 4: register index width; index 0 is hardwired zero and never creates a hazard.
- FLUSH_CYCLES, 1: extra cycles flush_id stays asserted after the redirect cycle (0..15; 0 means the redirect cycle only).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_W  ID source indices
- id_use_rs1, id_use_rs2  in  1  ID instruction reads that source
- ex1_valid  in  1  EX1 holds a real instruction
- ex1_is_load  in  1  EX1 instruction is a load
- ex1_rd  in  REG_W  EX1 destination
- ex2_valid, ex2_is_load  in  1  same, for EX2
- ex2_rd  in  REG_W  EX2 destination
- ex1_mc_start  in  1  first cycle of a multi-cycle op in EX1
- ex1_mc_lat  in  4  total EX1 latency L of that op (0 or 1 = single cycle)
- ex1_redirect  in  1  EX1 resolved a taken branch or jump
- stall_if  out  1  hold PC and IF/ID
- stall_id  out  1  hold ID stage
- hold_ex1  out  1  hold ID/EX1 contents
- bubble_ex1  out  1  load a bubble into ID/EX1
- bubble_ex2  out  1  load a bubble into EX1/EX2
- flush_id  out  1  invalidate IF/ID
- pc_redirect  out  1  select branch target for PC
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1
- flush_events  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Load data has no forward path into EX1; it is only available through the register-file write/read bypass in WB.
  - Therefore ld_use = id_valid and, for any used source rs != 0, (ex1_valid & ex1_is_load & ex1_rd==rs) or (ex2_valid & ex2_is_load & ex2_rd==rs).
  - Load-use penalty is 2 cycles.
- State register: RUN, MC_WAIT, FLUSH. Control outputs are combinational from the registered state, counter and inputs.
- Reset state is RUN; cnt=0; counters=0.
- While rst=1, outputs are forced regardless of inputs: stall_if=stall_id=hold_ex1=pc_redirect=0; flush_id=bubble_ex1=bubble_ex2=1.
- Reset mid-MC_WAIT or mid-FLUSH aborts to RUN on the next edge.
- RUN, evaluated in priority order:
  - Multi-cycle start (ex1_mc_start & L>=2):
    - Outputs: hold_ex1, stall_if, stall_id, bubble_ex2 = 1; bubble_ex1 = 0.
    - Load cnt = L-2; next state MC_WAIT.
    - ex1_redirect in the same cycle is ignored.
  - Redirect (ex1_redirect):
    - Outputs: pc_redirect, flush_id, bubble_ex1 = 1; stall outputs = 0.
    - flush_events++.
    - If FLUSH_CYCLES>0: cnt = FLUSH_CYCLES-1, next state FLUSH.
    - A redirect cancels any concurrent ld_use.
  - ld_use:
    - Outputs: stall_if, stall_id, bubble_ex1 = 1; bubble_ex2 = 0.
  - Otherwise: all control outputs = 0.
- MC_WAIT:
  - cnt != 0: same hold outputs as the start cycle; cnt--.
  - cnt == 0: release, i.e. no hold, so EX1 advances its result. Return to RUN.
  - On the release cycle, redirect and ld_use are evaluated exactly as in RUN, including entering FLUSH.
  - Total hold cycles = L-1.
- FLUSH:
  - Outputs: flush_id = bubble_ex1 = 1.
  - ex1_redirect, ex1_mc_start and ld_use are ignored.
  - cnt != 0: cnt--.
  - cnt == 0: return to RUN after this cycle.
  - flush_id is asserted for exactly FLUSH_CYCLES+1 consecutive cycles, counting the redirect cycle.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Load-use via EX1: load r3 in EX1, ID reads rs1=3 (use_rs1=1) -> stall_if=1 and bubble_ex1=1 for 2 consecutive cycles (load in EX1, then EX2), then 0; stall_cycles=2.
- r0 immunity: load with rd=0 in EX1, ID reads r0 -> no stall. Second case: use_rs2=0 with rs2 matching -> no stall.
- Multi-cycle: ex1_mc_start=1, L=4 -> hold_ex1=bubble_ex2=1 for 3 cycles, released in the 4th. L=1 -> no hold. L=2 -> exactly 1 hold cycle.
- Redirect with FLUSH_CYCLES=1, concurrent ld_use -> pc_redirect=1 for 1 cycle; flush_id=1 for 2 cycles; no stall; flush_events=1. Redirect asserted during FLUSH is ignored.
- Redirect on the mc_start cycle with L=3 -> redirect ignored. Redirect re-asserted on the release cycle -> accepted, FLUSH entered.
- rst asserted during MC_WAIT -> next cycle state RUN, stall outputs 0, counters 0. Counter driven with CNT_W=4 and 20 stall cycles -> holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage in-order pipeline (IF, ID, EX1, EX2, WB).
// Handles load-use stalls, multi-cycle EX1 holds and redirect flushes, and keeps saturating counters.
module pipe_hazard_ctrl #(
    parameter int REG_W        = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex1_valid,
    input  logic             ex1_is_load,
    input  logic [REG_W-1:0] ex1_rd,
    input  logic             ex2_valid,
    input  logic             ex2_is_load,
    input  logic [REG_W-1:0] ex2_rd,
    input  logic             ex1_mc_start,
    input  logic [3:0]       ex1_mc_lat,
    input  logic             ex1_redirect,
    output logic             stall_if,
    output logic             stall_id,
    output logic             hold_ex1,
    output logic             bubble_ex1,
    output logic             bubble_ex2,
    output logic             flush_id,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_e;

    localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             hit_rs1, hit_rs2, ld_use, mc_go, eval_run, redir_acc;

    // Load results reach EX1 only via the WB register-file bypass, so loads in EX1 and EX2 both block.
    function automatic logic src_hit(input logic [REG_W-1:0] rs, input logic use_rs);
        return use_rs && (rs != '0) &&
               ((ex1_valid && ex1_is_load && (ex1_rd == rs)) ||
                (ex2_valid && ex2_is_load && (ex2_rd == rs)));
    endfunction

    assign hit_rs1 = src_hit(id_rs1, id_use_rs1);
    assign hit_rs2 = src_hit(id_rs2, id_use_rs2);
    assign ld_use  = id_valid && (hit_rs1 || hit_rs2);
    assign mc_go   = ex1_mc_start && (ex1_mc_lat >= 4'd2);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        eval_run    = 1'b0;
        redir_acc   = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        hold_ex1    = 1'b0;
        bubble_ex1  = 1'b0;
        bubble_ex2  = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;

        case (state_q)
            RUN: begin
                if (mc_go) begin
                    {stall_if, stall_id, hold_ex1, bubble_ex2} = 4'b1111;
                    cnt_d   = ex1_mc_lat - 4'd2;
                    state_d = MC_WAIT;
                end else begin
                    eval_run = 1'b1;
                end
            end
            MC_WAIT: begin
                if (cnt_q != 4'd0) begin
                    {stall_if, stall_id, hold_ex1, bubble_ex2} = 4'b1111;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d  = RUN;
                    eval_run = 1'b1;
                end
            end
            FLUSH: begin
                flush_id   = 1'b1;
                bubble_ex1 = 1'b1;
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        // Redirect wins over load-use: the stalled ID instruction is on the wrong path anyway.
        if (eval_run) begin
            if (ex1_redirect) begin
                pc_redirect = 1'b1;
                flush_id    = 1'b1;
                bubble_ex1  = 1'b1;
                redir_acc   = 1'b1;
                if (FLUSH_CYCLES > 0) begin
                    cnt_d   = FLUSH_INIT;
                    state_d = FLUSH;
                end
            end else if (ld_use) begin
                stall_if   = 1'b1;
                stall_id   = 1'b1;
                bubble_ex1 = 1'b1;
            end
        end

        if (rst) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            hold_ex1    = 1'b0;
            pc_redirect = 1'b0;
            flush_id    = 1'b1;
            bubble_ex1  = 1'b1;
            bubble_ex2  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_if && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (redir_acc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with FLUSH_CYCLES=1 and 4-bit counters.
// Each applied vector pushes its expectation; the sample point pops and compares.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_RST = 7'b0001110;
    localparam logic [6:0] C_NO  = 7'b0000000;
    localparam logic [6:0] C_LDU = 7'b1101000;
    localparam logic [6:0] C_MC  = 7'b1110100;
    localparam logic [6:0] C_RED = 7'b0001011;
    localparam logic [6:0] C_FL  = 7'b0001010;

    typedef struct {
        string      nm;
        logic       r, idv, u1, u2, e1v, e1l, e2v, e2l, mcs, red;
        logic [3:0] rs1, rs2, e1rd, e2rd, lat;
        logic [6:0] ctl;
        logic [3:0] sc, fc;
    } vec_t;

    logic       clk, rst;
    logic       id_valid, id_use_rs1, id_use_rs2;
    logic [3:0] id_rs1, id_rs2, ex1_rd, ex2_rd, ex1_mc_lat;
    logic       ex1_valid, ex1_is_load, ex2_valid, ex2_is_load, ex1_mc_start, ex1_redirect;
    logic       stall_if, stall_id, hold_ex1, bubble_ex1, bubble_ex2, flush_id, pc_redirect;
    logic [3:0] stall_cycles, flush_events;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pipe_hazard_ctrl #(.REG_W(4), .FLUSH_CYCLES(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex1_valid(ex1_valid), .ex1_is_load(ex1_is_load), .ex1_rd(ex1_rd),
        .ex2_valid(ex2_valid), .ex2_is_load(ex2_is_load), .ex2_rd(ex2_rd),
        .ex1_mc_start(ex1_mc_start), .ex1_mc_lat(ex1_mc_lat), .ex1_redirect(ex1_redirect),
        .stall_if(stall_if), .stall_id(stall_id), .hold_ex1(hold_ex1),
        .bubble_ex1(bubble_ex1), .bubble_ex2(bubble_ex2), .flush_id(flush_id),
        .pc_redirect(pc_redirect), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, bit r, bit idv, int rs1, int rs2, bit u1, bit u2,
                                bit e1v, bit e1l, int e1rd, bit e2v, bit e2l, int e2rd,
                                bit mcs, int lat, bit red, logic [6:0] ctl, int sc, int fc);
        vec_t v;
        v.nm = nm; v.r = r; v.idv = idv; v.rs1 = 4'(rs1); v.rs2 = 4'(rs2); v.u1 = u1; v.u2 = u2;
        v.e1v = e1v; v.e1l = e1l; v.e1rd = 4'(e1rd); v.e2v = e2v; v.e2l = e2l; v.e2rd = 4'(e2rd);
        v.mcs = mcs; v.lat = 4'(lat); v.red = red; v.ctl = ctl; v.sc = 4'(sc); v.fc = 4'(fc);
        return v;
    endfunction

    function automatic vec_t idle(string nm, int sc, int fc);
        return mk(nm, 0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, C_NO, sc, fc);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs after the edge, then compare mid-cycle.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.r; id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex1_valid = v.e1v; ex1_is_load = v.e1l; ex1_rd = v.e1rd;
        ex2_valid = v.e2v; ex2_is_load = v.e2l; ex2_rd = v.e2rd;
        ex1_mc_start = v.mcs; ex1_mc_lat = v.lat; ex1_redirect = v.red;
        sb.push_back(v);
        #3;
        e = sb.pop_front();
        check({e.nm, " ctrl"}, int'({stall_if, stall_id, hold_ex1, bubble_ex1, bubble_ex2,
                                    flush_id, pc_redirect}), int'(e.ctl));
        check({e.nm, " stall_cycles"}, int'(stall_cycles), int'(e.sc));
        check({e.nm, " flush_events"}, int'(flush_events), int'(e.fc));
    endtask

    initial begin
        //            name         r idv rs1 rs2 u1 u2 e1v e1l e1rd e2v e2l e2rd mcs lat red ctl    sc fc
        tbl.push_back(mk("reset_forced", 1, 1,3,0,1,0, 1,1,3, 0,0,0, 1,4,1, C_RST, 0, 0));
        tbl.push_back(idle("idle", 0, 0));
        tbl.push_back(mk("ldu_ex1",    0, 1,3,0,1,0, 1,1,3, 0,0,0, 0,0,0, C_LDU, 0, 0));
        tbl.push_back(mk("ldu_ex2",    0, 1,3,0,1,0, 0,0,0, 1,1,3, 0,0,0, C_LDU, 1, 0));
        tbl.push_back(mk("ldu_done",   0, 1,3,0,1,0, 0,0,0, 0,0,0, 0,0,0, C_NO,  2, 0));
        tbl.push_back(mk("r0_immune",  0, 1,0,0,1,1, 1,1,0, 1,1,0, 0,0,0, C_NO,  2, 0));
        tbl.push_back(mk("rs2_unused", 0, 1,1,5,0,0, 1,1,5, 0,0,0, 0,0,0, C_NO,  2, 0));
        tbl.push_back(mk("rs2_ex2",    0, 1,1,5,0,1, 0,0,0, 1,1,5, 0,0,0, C_LDU, 2, 0));
        tbl.push_back(mk("ex2_noload", 0, 1,1,5,0,1, 1,0,5, 1,0,5, 0,0,0, C_NO,  3, 0));
        tbl.push_back(mk("mc4_start",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,4,0, C_MC,  3, 0));
        tbl.push_back(mk("mc4_hold1",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1, C_MC,  4, 0));
        tbl.push_back(idle("mc4_hold2", 5, 0));
        tbl.push_back(idle("mc4_release", 6, 0));
        tbl[11].ctl = C_MC;
        tbl.push_back(mk("mc1_nohold", 0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,1,0, C_NO,  6, 0));
        tbl.push_back(mk("mc2_start",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,2,0, C_MC,  6, 0));
        tbl.push_back(idle("mc2_release", 7, 0));
        tbl.push_back(mk("redir_ldu",  0, 1,3,0,1,0, 1,1,3, 0,0,0, 0,0,1, C_RED, 7, 0));
        tbl.push_back(mk("flush_ign",  0, 1,3,0,1,0, 1,1,3, 0,0,0, 1,4,1, C_FL,  7, 1));
        tbl.push_back(idle("flush_end", 7, 1));
        tbl.push_back(mk("mc3_redir",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,3,1, C_MC,  7, 1));
        tbl.push_back(idle("mc3_hold", 8, 1));
        tbl[20].ctl = C_MC;
        tbl.push_back(mk("rel_redir",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1, C_RED, 9, 1));
        tbl.push_back(mk("rel_flush",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, C_FL,  9, 2));
        tbl.push_back(idle("after_flush", 9, 2));
        tbl.push_back(mk("mc5_start",  0, 0,0,0,0,0, 0,0,0, 0,0,0, 1,5,0, C_MC,  9, 2));
        tbl.push_back(idle("mc5_hold", 10, 2));
        tbl[25].ctl = C_MC;
        tbl.push_back(mk("rst_in_mc",  1, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1, C_RST, 11, 2));
        tbl.push_back(idle("post_rst_run", 0, 0));

        rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex1_valid = 0; ex1_is_load = 0; ex1_rd = 0; ex2_valid = 0; ex2_is_load = 0; ex2_rd = 0;
        ex1_mc_start = 0; ex1_mc_lat = 0; ex1_redirect = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Stall counter saturation: 20 back-to-back load-use cycles.
        for (int i = 0; i < 20; i++)
            apply(mk("sat_stall", 0, 1,3,0,1,0, 1,1,3, 0,0,0, 0,0,0, C_LDU, (i > 15) ? 15 : i, 0));
        apply(idle("sat_stall_hold", 15, 0));

        // Flush counter saturation: 20 redirects, each followed by its flush cycle.
        for (int i = 0; i < 20; i++) begin
            apply(mk("sat_redir", 0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1, C_RED, 15, (i > 15) ? 15 : i));
            apply(mk("sat_flush", 0, 0,0,0,0,0, 0,0,0, 0,0,0, 0,0,1, C_FL, 15, (i + 1 > 15) ? 15 : i + 1));
        end
        apply(idle("sat_flush_hold", 15, 15));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
